corelet_ctrl: RTL

Sequencer that drives the 35-bit instruction bus of the 8x8 corelet for one weight-stationary (WS) tile. It fetches weights and activations from an external single-port SRAM into L0, loads the weights into the MAC array, streams the activations through, and drains the OFIFO into a psum SRAM. It sits between the top-level testbench/host and the corelet and replaces hand-written instruction sequences.

---
 rtl/corelet_pkg.sv | 40 ++++
 rtl/corelet_ctrl_fetch.sv | 57 +++++
 rtl/corelet_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/corelet_pkg.sv
//------------------------------------------------------------------------------
// Module   : corelet_pkg
// Brief    : Shared types and constants for the corelet instruction sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package corelet_pkg;

  // Corelet instruction word width and bit positions
  localparam int INST_W   = 35;
  localparam int MODE     = 34;
  localparam int OFIFO_RD = 6;
  localparam int IFIFO_WR = 5;
  localparam int IFIFO_RD = 4;
  localparam int L0_RD    = 3;
  localparam int L0_WR    = 2;
  localparam int EXECUTE  = 1;
  localparam int LOAD     = 0;

  // Sequencer states for one weight-stationary tile
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_FETCH = 3'd1,
    W_LOAD  = 3'd2,
    FLUSH   = 3'd3,
    X_FETCH = 3'd4,
    EXEC    = 3'd5,
    DRAIN   = 3'd6,
    DONE    = 3'd7
  } state_t;

  // Larger of two integers, used to size shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/corelet_ctrl_fetch.sv
//------------------------------------------------------------------------------
// Module   : ctrl_fetch
// Brief    : Shared SRAM read issuer for weight and activation fetches into L0.
//            Issues base+cnt reads while below target and L0 is not full, and
//            produces l0_wr one cycle behind each read to match SRAM latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_fetch #(
  parameter int ADDR_BW = 11,
  parameter int CNT_BW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [ADDR_BW-1:0] base,
  input  logic [CNT_BW-1:0]  target,
  input  logic               l0_o_full,
  output logic               mem_rd,
  output logic [ADDR_BW-1:0] mem_addr,
  output logic               l0_wr,
  output logic               fetch_done
);

  logic [CNT_BW-1:0] cnt;
  logic              issue;

  // A new read goes out only while reads remain and L0 has room
  assign issue = en && (cnt < target) && !l0_o_full;

  // Finished once every read is issued and the last one is no longer in flight
  assign fetch_done = en && (cnt == target) && !mem_rd;

  // Read strobe, address, delayed L0 write and the read counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      l0_wr    <= 1'b0;
    end else begin
      mem_rd   <= issue;
      mem_addr <= issue ? (base + ADDR_BW'(cnt)) : '0;
      // SRAM data lands one cycle after the read, so write L0 then
      l0_wr    <= mem_rd;
      if (!en) begin
        cnt <= '0;
      end else if (issue) begin
        cnt <= cnt + CNT_BW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/corelet_ctrl.sv
//------------------------------------------------------------------------------
// Module   : corelet_ctrl
// Brief    : Sequencer driving the 8x8 corelet instruction bus for one
//            weight-stationary tile: fetch W, load W, flush, fetch X, execute,
//            drain OFIFO into psum SRAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int ADDR_BW   = 11,
  parameter int LEN_BW    = 6,
  parameter int FLUSH_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_BW-1:0]  len,
  input  logic [ADDR_BW-1:0] w_base,
  input  logic [ADDR_BW-1:0] x_base,
  input  logic               l0_o_full,
  input  logic               ofifo_o_valid,
  output logic               mem_rd,
  output logic [ADDR_BW-1:0] mem_addr,
  output logic [INST_W-1:0]  inst,
  output logic               psum_wr,
  output logic [LEN_BW-1:0]  psum_addr,
  output logic               busy,
  output logic               done
);

  // The array needs at least ROW+COL idle cycles to settle after weight load
  localparam int FLUSH_CYC = max_int(FLUSH_LEN, ROW + COL);
  // One counter width big enough for every phase target
  localparam int CNT_BW = max_int(max_int($clog2(COL + 1), $clog2(FLUSH_CYC + 1)), LEN_BW);

  state_t             state;
  logic [CNT_BW-1:0]  cnt;
  logic [LEN_BW-1:0]  len_r;
  logic [ADDR_BW-1:0] w_base_r;
  logic [ADDR_BW-1:0] x_base_r;
  logic               load_r;
  logic               exec_r;
  logic               l0_rd_r;
  logic               ofifo_rd_r;

  logic               fetch_en;
  logic [ADDR_BW-1:0] fetch_base;
  logic [CNT_BW-1:0]  fetch_target;
  logic               fetch_done;
  logic               l0_wr;
  logic [CNT_BW-1:0]  len_cnt;

  assign len_cnt      = CNT_BW'(len_r);
  assign fetch_en     = (state == W_FETCH) || (state == X_FETCH);
  assign fetch_base   = (state == X_FETCH) ? x_base_r : w_base_r;
  assign fetch_target = (state == X_FETCH) ? len_cnt : CNT_BW'(COL);

  ctrl_fetch #(
    .ADDR_BW (ADDR_BW),
    .CNT_BW  (CNT_BW)
  ) u_fetch (
    .clk        (clk),
    .reset      (reset),
    .en         (fetch_en),
    .base       (fetch_base),
    .target     (fetch_target),
    .l0_o_full  (l0_o_full),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .l0_wr      (l0_wr),
    .fetch_done (fetch_done)
  );

  // Instruction word assembled from registered control bits; WS mode, no IFIFO
  always_comb begin
    inst           = '0;
    inst[MODE]     = 1'b0;
    inst[IFIFO_WR] = 1'b0;
    inst[IFIFO_RD] = 1'b0;
    inst[OFIFO_RD] = ofifo_rd_r;
    inst[L0_RD]    = l0_rd_r;
    inst[L0_WR]    = l0_wr;
    inst[EXECUTE]  = exec_r;
    inst[LOAD]     = load_r;
  end

  // Tile sequencer: state, phase counter and registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      len_r      <= '0;
      w_base_r   <= '0;
      x_base_r   <= '0;
      load_r     <= 1'b0;
      exec_r     <= 1'b0;
      l0_rd_r    <= 1'b0;
      ofifo_rd_r <= 1'b0;
      psum_wr    <= 1'b0;
      psum_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      psum_wr    <= 1'b0;
      ofifo_rd_r <= 1'b0;
      // Address advances after each write so it names the row being written
      if (psum_wr) begin
        psum_addr <= psum_addr + LEN_BW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= W_FETCH;
            busy      <= 1'b1;
            len_r     <= (len == '0) ? LEN_BW'(1) : len;
            w_base_r  <= w_base;
            x_base_r  <= x_base;
            psum_addr <= '0;
            cnt       <= '0;
          end
        end
        W_FETCH: begin
          if (fetch_done) begin
            state   <= W_LOAD;
            load_r  <= 1'b1;
            l0_rd_r <= 1'b1;
            cnt     <= '0;
          end
        end
        W_LOAD: begin
          if (cnt == CNT_BW'(COL - 1)) begin
            state   <= FLUSH;
            load_r  <= 1'b0;
            l0_rd_r <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_BW'(1);
          end
        end
        FLUSH: begin
          if (cnt == CNT_BW'(FLUSH_CYC - 1)) begin
            state <= X_FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_BW'(1);
          end
        end
        X_FETCH: begin
          if (fetch_done) begin
            state   <= EXEC;
            exec_r  <= 1'b1;
            l0_rd_r <= 1'b1;
            cnt     <= '0;
          end
        end
        EXEC: begin
          if (cnt == len_cnt - CNT_BW'(1)) begin
            state   <= DRAIN;
            exec_r  <= 1'b0;
            l0_rd_r <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_BW'(1);
          end
        end
        DRAIN: begin
          if (cnt == len_cnt) begin
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else if (ofifo_o_valid) begin
            ofifo_rd_r <= 1'b1;
            psum_wr    <= 1'b1;
            cnt        <= cnt + CNT_BW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
